mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Load/store front-end that drives the word-organised datamemory (6-bit word address, 32-bit data,
//  single we/ce). Accepts byte/half/word requests on a byte address via valid/ready, does
//  read-modify-write for sub-word stores, and sign/zero-extends sub-word loads.
//  Sits between the CPU execute stage and datamemory.
// PARAMETERS
//  BYTE_AW  8   byte-address width; word address = req_addr[BYTE_AW-1:2] (localparam WORD_AW = BYTE_AW-2 = 6)
//  DATA_W   32  data width; only 32 is supported
// PORTS
//  clk          in   1        single clock, rising edge
//  rst_n        in   1        synchronous, active-low reset
//  req_valid    in   1        request present
//  req_ready    out  1        request accepted when req_valid & req_ready at a rising edge
//  req_we       in   1        1 = store, 0 = load
//  req_size     in   2        00 byte, 01 half, 10 word, 11 illegal
//  req_signed   in   1        loads: 1 = sign-extend, 0 = zero-extend
//  req_addr     in   BYTE_AW  byte address
//  req_wdata    in   32       store data, right-aligned (byte in [7:0], half in [15:0])
//  resp_valid   out  1        one-cycle completion pulse, no back-pressure
//  resp_err     out  1        valid with resp_valid: misaligned/illegal request, no memory access
//  resp_rdata   out  32       load result, extended; 0 for stores and errors
//  mem_address  out  WORD_AW  to datamemory address
//  mem_dataIn   out  32       to datamemory dataIn
//  mem_dataOut  in   32       from datamemory dataOut; valid the cycle after a read with ce=1, we=0
//  mem_we       out  1        to datamemory we
//  mem_ce       out  1        to datamemory ce
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1 after reset releases. resp_valid, resp_err, mem_we and mem_ce are 0.
//    resp_rdata, mem_address and mem_dataIn are 0.
//  - Little-endian lanes: byte k = bits [8k+7:8k], k = req_addr[1:0]; half at addr[1]=0 -> [15:0], 1 -> [31:16].
//  - Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size=11. Goes to ERR.
//  - FSM states: IDLE, RD, CAPT, WR, RESP, ERR.
//    - IDLE: req_ready=1. On accept, latch the request, then go to:
//      - ERR if misaligned;
//      - WR if a word store;
//      - RD otherwise.
//    - RD: mem_ce=1, mem_we=0, mem_address = word addr. Next state CAPT.
//    - CAPT: sample mem_dataOut.
//      - Load: extract and extend into resp_rdata, then RESP.
//      - Store: merge wdata lanes into the sampled word, register the result as the write word, then WR.
//    - WR: mem_ce=1, mem_we=1, mem_dataIn = write word. Next state RESP.
//    - RESP: resp_valid=1, resp_err=0. Next state IDLE.
//    - ERR: resp_valid=1, resp_err=1, resp_rdata=0. Next state IDLE.
//  - req_ready=0 in every state except IDLE. A new request can be accepted in the cycle after resp_valid.
//  - Latency, counted from the accept edge T to the resp_valid cycle:
//    - error: 1 (ERR during T..T+1);
//    - word store: 2 (WR, RESP);
//    - load: 3 (RD, CAPT, RESP);
//    - sub-word store: 4 (RD, CAPT, WR, RESP).
//  - mem_ce and mem_we are registered outputs and are 1 only in RD / WR. mem_we=1 implies mem_ce=1.
//    Outside RD/WR, mem_address and mem_dataIn hold their last values.
//  - Memory is written only in WR, exactly one cycle per store. Unselected lanes of a sub-word store
//    keep the value read in RD.
//  - Extension: byte bit 7 / half bit 15 is replicated when req_signed=1; the upper bits are 0 otherwise.
//    Word loads ignore req_signed.
//  - Request inputs are ignored while req_ready=0. They need not be held after acceptance.
//  - Reset mid-operation: on the rst_n=0 edge the FSM returns to IDLE and mem_ce, mem_we and resp_valid
//    go to 0. An RMW aborted before WR leaves memory unchanged. No response is issued for the aborted request.
// STRUCTURE
//  - Package mem_access_pkg holds:
//    - SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_ILL encodings;
//    - state encoding localparams;
//    - the WORD_AW derivation.
//  - Sub-module mem_lane_unit (combinational):
//    - lane extract + sign/zero extend for loads;
//    - lane merge for stores.
//  - The FSM and registers stay in mem_access_ctrl.
// TESTING
//  1. Word store 32'hDEADBEEF @addr 8'h28, then word load @8'h28 -> mem_address=10 with one WR cycle;
//     load resp_rdata=32'hDEADBEEF after 3 cycles; resp_err=0.
//  2. Byte store 8'h80 @8'h29 onto word 32'h11223344 -> RD, then WR with mem_dataIn=32'h11228044.
//     Signed byte load @8'h29 -> 32'hFFFFFF80; unsigned -> 32'h00000080.
//  3. Half store 16'hA5A5 @8'h2E onto 0 -> WR 32'hA5A50000. Signed half load @8'h2E -> 32'hFFFFA5A5.
//  4. Misaligned: half @8'h01, word @8'h02, size=11 -> resp_valid & resp_err one cycle after accept,
//     resp_rdata=0, mem_ce stays 0.
//  5. Back-to-back: req_valid held high with 3 requests -> each accepted only in IDLE, in order.
//     Exactly one resp_valid per request and correct latencies 2/3/4.
//  6. rst_n=0 during CAPT of a byte store -> next cycle IDLE, mem_we never 1, target word unchanged,
//     no resp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Purpose : Shared types and constants for the load/store front-end.
//           Holds the access-size encoding, the controller FSM state encoding,
//           the byte-to-word address width derivation and the alignment rule.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package mem_access_pkg;

  localparam int DEF_BYTE_AW = 8;

  // The datamemory is word organised, so the two lowest byte-address bits
  // select a lane and never reach the memory address port.
  function automatic int word_aw_of(input int byte_aw);
    return byte_aw - 2;
  endfunction

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAPT = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  // A request is rejected when it straddles its natural alignment or uses
  // the reserved size code.
  function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
    logic bad;
    case (sz)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = off[0];
      SIZE_WORD: bad = (off != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// -----------------------------------------------------------------------------
// mem_lane_unit
// Purpose : Combinational lane logic between a 32-bit memory word and a
//           right-aligned sub-word value (little-endian lanes).
// Ports   : size_i   access size
//           off_i    byte offset within the word (byte address [1:0])
//           sign_i   1 = sign-extend loads, 0 = zero-extend
//           rword_i  word read from memory
//           wdata_i  right-aligned store data
//           load_o   extracted and extended load result
//           merge_o  rword_i with the selected lanes replaced by wdata_i
// -----------------------------------------------------------------------------
module mem_lane_unit
  import mem_access_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  off_i,
  input  logic        sign_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [31:0] wrep;
  logic [3:0]  lane_sel;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Replicating the store data across the word puts the right bits in every
  // candidate lane; lane_sel then decides which lanes actually take it.
  always_comb begin
    case (size_i)
      SIZE_BYTE: wrep = {4{wdata_i[7:0]}};
      SIZE_HALF: wrep = {2{wdata_i[15:0]}};
      default:   wrep = wdata_i;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE_IDX = 2'(gi);
      localparam logic       LANE_HI  = LANE_IDX[1];

      assign lane_sel[gi] = (size_i == SIZE_WORD)
                          | ((size_i == SIZE_HALF) & (off_i[1] == LANE_HI))
                          | ((size_i == SIZE_BYTE) & (off_i == LANE_IDX));

      assign merge_o[8*gi +: 8] = lane_sel[gi] ? wrep[8*gi +: 8] : rword_i[8*gi +: 8];
    end
  endgenerate

  assign byte_v = rword_i[{off_i, 3'b000} +: 8];
  assign half_v = off_i[1] ? rword_i[31:16] : rword_i[15:0];

  always_comb begin
    case (size_i)
      SIZE_BYTE: load_o = {{24{sign_i & byte_v[7]}}, byte_v};
      SIZE_HALF: load_o = {{16{sign_i & half_v[15]}}, half_v};
      default:   load_o = rword_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Purpose : Load/store front-end for the word-organised datamemory. Accepts
//           byte/half/word requests on a byte address, performs
//           read-modify-write for sub-word stores and extends sub-word loads.
// Ports   : clk, rst_n (synchronous, active low)
//           req_valid/req_ready handshake; req_we, req_size, req_signed,
//           req_addr, req_wdata request fields
//           resp_valid (one-cycle pulse), resp_err, resp_rdata
//           mem_address, mem_dataIn, mem_we, mem_ce to datamemory;
//           mem_dataOut from datamemory (valid the cycle after a read)
// -----------------------------------------------------------------------------
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter  int BYTE_AW = DEF_BYTE_AW,
  parameter  int DATA_W  = 32,
  localparam int WORD_AW = word_aw_of(BYTE_AW)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_signed,
  input  logic [BYTE_AW-1:0] req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  output logic               resp_valid,
  output logic               resp_err,
  output logic [DATA_W-1:0]  resp_rdata,
  output logic [WORD_AW-1:0] mem_address,
  output logic [DATA_W-1:0]  mem_dataIn,
  input  logic [DATA_W-1:0]  mem_dataOut,
  output logic               mem_we,
  output logic               mem_ce
);

  state_e              state_q, state_d;
  logic                we_q;
  size_e               size_q;
  logic                sign_q;
  logic [1:0]          off_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mem_ce_q, mem_ce_d;
  logic                mem_we_q, mem_we_d;
  logic [WORD_AW-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_din_q, mem_din_d;

  logic                accept;
  logic                misaligned;
  logic [DATA_W-1:0]   lane_load;
  logic [DATA_W-1:0]   lane_merge;

  assign accept     = req_valid & (state_q == ST_IDLE);
  assign misaligned = is_misaligned(size_e'(req_size), req_addr[1:0]);

  mem_lane_unit u_lane (
    .size_i  (size_q),
    .off_i   (off_q),
    .sign_i  (sign_q),
    .rword_i (mem_dataOut),
    .wdata_i (wdata_q),
    .load_o  (lane_load),
    .merge_o (lane_merge)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (misaligned) begin
            state_d = ST_ERR;
          end else if (req_we && (size_e'(req_size) == SIZE_WORD)) begin
            // A full word needs no read-back; skip straight to the write.
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD:   state_d = ST_CAPT;
      ST_CAPT: state_d = we_q ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: memory strobes are computed from the upcoming state so the
  // registered versions line up exactly with RD and WR.
  always_comb begin
    mem_ce_d   = (state_d == ST_RD) || (state_d == ST_WR);
    mem_we_d   = (state_d == ST_WR);
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    rdata_d    = rdata_q;

    if (accept) begin
      rdata_d = '0;
      if (!misaligned) begin
        mem_addr_d = req_addr[BYTE_AW-1:2];
      end
      if (state_d == ST_WR) begin
        mem_din_d = req_wdata;
      end
    end

    if (state_q == ST_CAPT) begin
      if (we_q) begin
        mem_din_d = lane_merge;
      end else begin
        rdata_d = lane_load;
      end
    end

    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_RESP) || (state_q == ST_ERR);
    resp_err   = (state_q == ST_ERR);
  end

  // Request latch and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      size_q     <= SIZE_BYTE;
      sign_q     <= 1'b0;
      off_q      <= 2'b00;
      wdata_q    <= '0;
      rdata_q    <= '0;
      mem_ce_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        size_q  <= size_e'(req_size);
        sign_q  <= req_signed;
        off_q   <= req_addr[1:0];
        wdata_q <= req_wdata;
      end
      rdata_q    <= rdata_d;
      mem_ce_q   <= mem_ce_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
    end
  end

  assign resp_rdata  = rdata_q;
  assign mem_ce      = mem_ce_q;
  assign mem_we      = mem_we_q;
  assign mem_address = mem_addr_q;
  assign mem_dataIn  = mem_din_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Purpose : Self-checking bench for mem_access_ctrl. Contains a 64-word
//           datamemory, a transaction-level reference model (shadow memory,
//           per-request latency countdown) and a per-cycle compare process.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [5:0]  mem_address;
  logic [31:0] mem_dataIn, mem_dataOut;
  logic        mem_we, mem_ce;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  bit clear_mem;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_err    (resp_err),
    .resp_rdata  (resp_rdata),
    .mem_address (mem_address),
    .mem_dataIn  (mem_dataIn),
    .mem_dataOut (mem_dataOut),
    .mem_we      (mem_we),
    .mem_ce      (mem_ce)
  );

  typedef struct {
    bit        we;
    bit [1:0]  size;
    bit        sgn;
    bit [7:0]  addr;
    bit [31:0] wdata;
  } req_t;

  typedef struct {
    bit [5:0]  addr;
    bit [31:0] data;
  } wr_t;

  typedef struct {
    bit        err;
    bit [31:0] rdata;
  } rsp_t;

  wr_t  wlog[$];
  rsp_t rlog[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
  endfunction

  // Datamemory: synchronous write, registered read.
  logic [31:0] ram [64];
  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
    end else if (mem_ce) begin
      if (mem_we) begin
        ram[mem_address] <= mem_dataIn;
        wlog.push_back('{mem_address, mem_dataIn});
      end else begin
        mem_dataOut <= ram[mem_address];
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic bit [31:0] f_merge(input bit [31:0] old, input bit [31:0] wd,
                                        input bit [1:0] sz, input bit [1:0] off);
    int sh;
    bit [31:0] mask;
    case (sz)
      2'd0: begin
        sh = int'(off) * 8;
        mask = 32'hFF << sh;
        return (old & ~mask) | ((wd & 32'hFF) << sh);
      end
      2'd1: begin
        sh = int'(off[1]) * 16;
        mask = 32'hFFFF << sh;
        return (old & ~mask) | ((wd & 32'hFFFF) << sh);
      end
      default: return wd;
    endcase
  endfunction

  function automatic bit [31:0] f_ext(input bit [31:0] w, input bit [1:0] sz,
                                      input bit [1:0] off, input bit sgn);
    bit [31:0] v;
    case (sz)
      2'd0: begin
        v = (w >> (int'(off) * 8)) & 32'hFF;
        if (sgn && v[7]) v = v | 32'hFFFFFF00;
      end
      2'd1: begin
        v = (w >> (int'(off[1]) * 16)) & 32'hFFFF;
        if (sgn && v[15]) v = v | 32'hFFFF0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic bit f_bad(input bit [1:0] sz, input bit [1:0] off);
    return (sz == 2'd3) || (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0);
  endfunction

  // cnt = cycles left until the request has fully completed; the response
  // appears when cnt==1 and the bench is ready again when cnt==0.
  int        cnt = 0;
  bit        acc_ev = 0;
  bit        m_err, m_store, m_sub;
  bit [5:0]  m_addr;
  bit [31:0] m_wword, m_rdata;
  bit [31:0] shadow [64];

  always @(posedge clk) begin : model
    bit [31:0] old;
    acc_ev = 0;
    if (clear_mem) begin
      for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
    end
    if (!rst_n) begin
      cnt = 0;
    end else if (cnt > 0) begin
      // The write lands in memory at the end of the cycle before the response.
      if (cnt == 2 && m_store) shadow[m_addr] = m_wword;
      cnt = cnt - 1;
    end else if (req_valid) begin
      acc_ev  = 1;
      m_err   = f_bad(req_size, req_addr[1:0]);
      m_addr  = req_addr[7:2];
      m_store = req_we && !m_err;
      m_sub   = m_store && (req_size != 2'd2);
      old     = shadow[m_addr];
      m_rdata = 32'h0;
      if (m_err) begin
        cnt = 1;
      end else if (req_we) begin
        m_wword = f_merge(old, req_wdata, req_size, req_addr[1:0]);
        cnt = m_sub ? 4 : 2;
      end else begin
        m_rdata = f_ext(old, req_size, req_addr[1:0], req_signed);
        cnt = 3;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    bit e_rv, e_we, e_ce;
    if (chk_en) begin
      e_rv = (cnt == 1);
      e_we = m_store && (cnt == 2);
      e_ce = e_we || (m_sub && cnt == 4) || (!m_store && !m_err && cnt == 3);
      chk("req_ready", {31'b0, req_ready}, {31'b0, cnt == 0});
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, e_rv});
      chk("resp_err", {31'b0, resp_err}, {31'b0, e_rv && m_err});
      chk("mem_ce", {31'b0, mem_ce}, {31'b0, e_ce});
      chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
      if (e_rv) chk("resp_rdata", resp_rdata, m_rdata);
      if (e_ce) chk("mem_address", {26'b0, mem_address}, {26'b0, m_addr});
      if (e_we) chk("mem_dataIn", mem_dataIn, m_wword);
      if (resp_valid) rlog.push_back('{resp_err, resp_rdata});
    end
  end

  // ---------------- stimulus ----------------
  function automatic req_t mk(input bit we, input bit [1:0] sz, input bit sgn,
                              input bit [7:0] a, input bit [31:0] wd);
    req_t r;
    r.we = we; r.size = sz; r.sgn = sgn; r.addr = a; r.wdata = wd;
    return r;
  endfunction

  function automatic req_t junk();
    return mk(1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom), $urandom);
  endfunction

  task automatic drive(input req_t r, input bit v);
    req_valid  = v;
    req_we     = r.we;
    req_size   = r.size;
    req_signed = r.sgn;
    req_addr   = r.addr;
    req_wdata  = r.wdata;
  endtask

  // Presents r as soon as the controller is free; while busy it drives random
  // request fields, with req_valid held high when hold=1.
  task automatic run_req(input req_t r, input bit hold);
    int guard = 0;
    while (1) begin
      if (cnt == 0) drive(r, 1'b1);
      else drive(junk(), hold);
      @(posedge clk); #1;
      if (acc_ev) break;
      guard++;
      if (guard > 40) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: request addr %h not accepted within 40 cycles", r.addr);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    drive(junk(), 1'b0);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    drive(junk(), 1'b0);
    while (cnt != 0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL idle_timeout: transaction still open cnt=%0d", cnt);
    end
  endtask

  initial begin : main
    req_t  dir[$];
    req_t  r;
    int    v;

    rst_n = 1'b0;
    clear_mem = 1'b1;
    drive(junk(), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_mem = 1'b0;

    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_mem_ce", {31'b0, mem_ce}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_address", {26'b0, mem_address}, 32'd0);
    chk("rst_mem_dataIn", mem_dataIn, 32'd0);
    chk_en = 1;

    // Hand-computed values pinning the reference model.
    chk("pin_merge_byte", f_merge(32'h11223344, 32'h80, 2'd0, 2'd1), 32'h11228044);
    chk("pin_merge_half", f_merge(32'h0, 32'hA5A5, 2'd1, 2'd2), 32'hA5A50000);
    chk("pin_ext_sbyte", f_ext(32'h11228044, 2'd0, 2'd1, 1'b1), 32'hFFFFFF80);
    chk("pin_ext_ubyte", f_ext(32'h11228044, 2'd0, 2'd1, 1'b0), 32'h00000080);
    chk("pin_ext_shalf", f_ext(32'hA5A50000, 2'd1, 2'd2, 1'b1), 32'hFFFFA5A5);

    @(posedge clk); #1;

    // Directed sequence, issued back-to-back with req_valid held high.
    dir.push_back(mk(1, 2'd2, 0, 8'h28, 32'hDEADBEEF));  // 0 word store
    dir.push_back(mk(0, 2'd2, 1, 8'h28, 32'h0));         // 1 word load
    dir.push_back(mk(1, 2'd2, 0, 8'h28, 32'h11223344));  // 2 word store
    dir.push_back(mk(1, 2'd0, 0, 8'h29, 32'hFFFFFF80));  // 3 byte store
    dir.push_back(mk(0, 2'd0, 1, 8'h29, 32'h0));         // 4 signed byte load
    dir.push_back(mk(0, 2'd0, 0, 8'h29, 32'h0));         // 5 unsigned byte load
    dir.push_back(mk(1, 2'd2, 0, 8'h2C, 32'h0));         // 6 word store 0
    dir.push_back(mk(1, 2'd1, 0, 8'h2E, 32'h1234A5A5));  // 7 half store
    dir.push_back(mk(0, 2'd1, 1, 8'h2E, 32'h0));         // 8 signed half load
    dir.push_back(mk(0, 2'd1, 0, 8'h01, 32'h0));         // 9 misaligned half
    dir.push_back(mk(1, 2'd2, 0, 8'h02, 32'h55));        // 10 misaligned word
    dir.push_back(mk(0, 2'd3, 0, 8'h00, 32'h0));         // 11 illegal size
    rlog.delete();
    wlog.delete();
    foreach (dir[i]) run_req(dir[i], 1'b1);
    wait_idle();
    idle(2);

    chk("dir_resp_count", rlog.size(), 32'd12);
    chk("dir_write_count", wlog.size(), 32'd5);
    if (rlog.size() == 12) begin
      chk("dir_word_load", rlog[1].rdata, 32'hDEADBEEF);
      chk("dir_word_load_err", {31'b0, rlog[1].err}, 32'd0);
      chk("dir_sbyte_load", rlog[4].rdata, 32'hFFFFFF80);
      chk("dir_ubyte_load", rlog[5].rdata, 32'h00000080);
      chk("dir_shalf_load", rlog[8].rdata, 32'hFFFFA5A5);
      for (int i = 9; i < 12; i++) begin
        chk("dir_err_flag", {31'b0, rlog[i].err}, 32'd1);
        chk("dir_err_rdata", rlog[i].rdata, 32'd0);
      end
    end
    if (wlog.size() == 5) begin
      chk("dir_wr0_addr", {26'b0, wlog[0].addr}, 32'd10);
      chk("dir_wr0_data", wlog[0].data, 32'hDEADBEEF);
      chk("dir_wr2_data", wlog[2].data, 32'h11228044);
      chk("dir_wr4_addr", {26'b0, wlog[4].addr}, 32'd11);
      chk("dir_wr4_data", wlog[4].data, 32'hA5A50000);
    end

    // Reset asserted while a byte store sits in CAPT.
    rlog.delete();
    wlog.delete();
    run_req(mk(1, 2'd0, 0, 8'h29, 32'h7E), 1'b0);  // now in RD
    drive(junk(), 1'b0);
    @(posedge clk); #1;                              // now in CAPT
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    idle(3);
    chk("rst_mid_word", ram[10], 32'h11228044);
    chk("rst_mid_writes", wlog.size(), 32'd0);
    chk("rst_mid_resps", rlog.size(), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      r.we  = 1'($urandom);
      v     = int'($urandom_range(0, 9));
      r.size = (v < 3) ? 2'd0 : (v < 6) ? 2'd1 : (v < 9) ? 2'd2 : 2'd3;
      r.sgn = 1'($urandom);
      r.addr = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(8'h20, 8'h3F)) : 8'($urandom);
      r.wdata = $urandom;
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      run_req(r, 1'($urandom));
    end
    wait_idle();
    idle(2);

    for (int i = 0; i < 64; i++) chk("final_mem_word", ram[i], shadow[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
